// File: rtl/mem_stage_module_if.sv
// Handshake and MEM/WB bundle between the execute-stage register, the memory
// stage and write-back.
interface mem_stage_module_if;
    logic        wb_enable_in;
    logic        mem_read_enable_in;
    logic        mem_write_enable_in;
    logic [3:0]  dest_in;
    logic [31:0] alu_result_in;
    logic [31:0] val_rm_in;
    logic        ready;
    logic        wb_enable_out;
    logic        mem_read_enable_out;
    logic [3:0]  dest_out;
    logic [31:0] alu_result_out;
    logic [31:0] mem_data_out;

    modport slave (
        input  wb_enable_in, mem_read_enable_in, mem_write_enable_in,
        input  dest_in, alu_result_in, val_rm_in,
        output ready, wb_enable_out, mem_read_enable_out,
        output dest_out, alu_result_out, mem_data_out
    );

    modport master (
        output wb_enable_in, mem_read_enable_in, mem_write_enable_in,
        output dest_in, alu_result_in, val_rm_in,
        input  ready, wb_enable_out, mem_read_enable_out,
        input  dest_out, alu_result_out, mem_data_out
    );
endinterface

// File: rtl/mem_stage_module.sv
// Memory stage: multi-cycle word load/store against an internal data memory,
// stalling upstream via ready and driving the MEM/WB pipeline register.
module mem_stage_module #(
    parameter int MEM_DEPTH   = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_stage_module_if.slave   bus
);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [3:0]         cnt_r;
    logic [31:0]        mem_r [MEM_DEPTH];
    logic [IDX_W-1:0]   idx_s;
    logic               mem_req_s;
    logic               ready_s;
    logic               wb_enable_r;
    logic               mem_read_enable_r;
    logic [3:0]         dest_r;
    logic [31:0]        alu_result_r;
    logic [31:0]        mem_data_r;

    // Request decode and word index; out-of-range addresses wrap by truncation.
    always_comb begin
        mem_req_s = bus.mem_read_enable_in | bus.mem_write_enable_in;
        idx_s     = IDX_W'((bus.alu_result_in - 32'(BASE_ADDR)) >> 2);
    end

    // Upstream handshake: consumed in IDLE without a request, or on DONE.
    always_comb begin
        ready_s = 1'b1;
        if (!rst) begin
            ready_s = 1'b1;
        end else begin
            case (state_r)
                IDLE:    ready_s = ~mem_req_s;
                BUSY:    ready_s = 1'b0;
                DONE:    ready_s = 1'b1;
                default: ready_s = 1'b1;
            endcase
        end
    end

    // Access sequencing and the MEM/WB register; stalled cycles load bubbles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r           <= IDLE;
            cnt_r             <= 4'd0;
            wb_enable_r       <= 1'b0;
            mem_read_enable_r <= 1'b0;
            dest_r            <= 4'd0;
            alu_result_r      <= 32'd0;
            mem_data_r        <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (mem_req_s) begin
                        wb_enable_r       <= 1'b0;
                        mem_read_enable_r <= 1'b0;
                        dest_r            <= 4'd0;
                        alu_result_r      <= 32'd0;
                        mem_data_r        <= 32'd0;
                        cnt_r             <= 4'd0;
                        state_r           <= BUSY;
                    end else begin
                        wb_enable_r       <= bus.wb_enable_in;
                        mem_read_enable_r <= bus.mem_read_enable_in;
                        dest_r            <= bus.dest_in;
                        alu_result_r      <= bus.alu_result_in;
                        mem_data_r        <= 32'd0;
                    end
                end
                BUSY: begin
                    wb_enable_r       <= 1'b0;
                    mem_read_enable_r <= 1'b0;
                    dest_r            <= 4'd0;
                    alu_result_r      <= 32'd0;
                    mem_data_r        <= 32'd0;
                    cnt_r             <= cnt_r + 4'd1;
                    if (cnt_r == 4'(WAIT_CYCLES - 1)) begin
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    wb_enable_r       <= bus.wb_enable_in;
                    mem_read_enable_r <= bus.mem_read_enable_in;
                    dest_r            <= bus.dest_in;
                    alu_result_r      <= bus.alu_result_in;
                    // Read sees pre-write contents when a store commits on the same edge.
                    mem_data_r        <= bus.mem_read_enable_in ? mem_r[idx_s] : 32'd0;
                    state_r           <= IDLE;
                end
                default: begin
                    wb_enable_r       <= 1'b0;
                    mem_read_enable_r <= 1'b0;
                    dest_r            <= 4'd0;
                    alu_result_r      <= 32'd0;
                    mem_data_r        <= 32'd0;
                    cnt_r             <= 4'd0;
                    state_r           <= IDLE;
                end
            endcase
        end
    end

    // Data memory store port; contents survive reset, stores commit only on DONE.
    always_ff @(posedge clk) begin
        if (rst && (state_r == DONE) && bus.mem_write_enable_in) begin
            mem_r[idx_s] <= bus.val_rm_in;
        end
    end

    assign bus.ready               = ready_s;
    assign bus.wb_enable_out       = wb_enable_r;
    assign bus.mem_read_enable_out = mem_read_enable_r;
    assign bus.dest_out            = dest_r;
    assign bus.alu_result_out      = alu_result_r;
    assign bus.mem_data_out        = mem_data_r;
endmodule

// File: tb/tb_mem_stage_module.sv
// Directed self-checking bench for mem_stage_module.
module tb_mem_stage_module;
    localparam int MEM_DEPTH   = 64;
    localparam int BASE_ADDR   = 1024;
    localparam int WAIT_CYCLES = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mem_stage_module_if bus ();

    mem_stage_module #(
        .MEM_DEPTH   (MEM_DEPTH),
        .BASE_ADDR   (BASE_ADDR),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input logic wb, input logic rd, input logic wr,
                              input logic [3:0] dest, input logic [31:0] addr,
                              input logic [31:0] data);
        bus.wb_enable_in        = wb;
        bus.mem_read_enable_in  = rd;
        bus.mem_write_enable_in = wr;
        bus.dest_in             = dest;
        bus.alu_result_in       = addr;
        bus.val_rm_in           = data;
    endtask

    // Issue one memory instruction, check the stall length, and leave the
    // MEM/WB result on the outputs (state back in IDLE) on return.
    task automatic mem_access(input string tag, input logic wb, input logic rd,
                              input logic wr, input logic [3:0] dest,
                              input logic [31:0] addr, input logic [31:0] data);
        int low_cnt;
        set_inputs(wb, rd, wr, dest, addr, data);
        #1;
        low_cnt = 0;
        while (bus.ready == 1'b0 && low_cnt < 50) begin
            low_cnt++;
            tick();
            if (bus.ready == 1'b0) check_value({tag, "_stall_wb"}, 32'(bus.wb_enable_out), 32'd0);
        end
        check_value({tag, "_ready_low"}, 32'(low_cnt), 32'(WAIT_CYCLES + 1));
        check_value({tag, "_done_ready"}, 32'(bus.ready), 32'd1);
        tick();
        set_inputs(1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b0;
        set_inputs(1'b1, 1'b0, 1'b1, 4'h5, 32'd1036, 32'h00000BAD);
        tick();
        tick();
        check_value("rst_ready", 32'(bus.ready), 32'd1);
        check_value("rst_wb", 32'(bus.wb_enable_out), 32'd0);
        check_value("rst_rd", 32'(bus.mem_read_enable_out), 32'd0);
        check_value("rst_dest", 32'(bus.dest_out), 32'd0);
        check_value("rst_alu", bus.alu_result_out, 32'd0);
        check_value("rst_data", bus.mem_data_out, 32'd0);
        set_inputs(1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        rst = 1'b1;
        tick();

        // ALU pass-through
        set_inputs(1'b1, 1'b0, 1'b0, 4'h3, 32'h00000055, 32'h0);
        #1;
        check_value("pass_ready", 32'(bus.ready), 32'd1);
        tick();
        check_value("pass_wb", 32'(bus.wb_enable_out), 32'd1);
        check_value("pass_dest", 32'(bus.dest_out), 32'd3);
        check_value("pass_alu", bus.alu_result_out, 32'h00000055);
        check_value("pass_data", bus.mem_data_out, 32'd0);
        check_value("pass_rd", 32'(bus.mem_read_enable_out), 32'd0);

        // Store then back-to-back load
        mem_access("st", 1'b0, 1'b0, 1'b1, 4'h0, 32'd1028, 32'hDEADBEEF);
        check_value("st_wb", 32'(bus.wb_enable_out), 32'd0);
        mem_access("ld", 1'b1, 1'b1, 1'b0, 4'h7, 32'd1028, 32'h0);
        check_value("ld_data", bus.mem_data_out, 32'hDEADBEEF);
        check_value("ld_rd", 32'(bus.mem_read_enable_out), 32'd1);
        check_value("ld_dest", 32'(bus.dest_out), 32'd7);
        check_value("ld_wb", 32'(bus.wb_enable_out), 32'd1);
        check_value("ld_alu", bus.alu_result_out, 32'd1028);

        // Byte offset bits ignored
        mem_access("ldoff", 1'b1, 1'b1, 1'b0, 4'h2, 32'd1030, 32'h0);
        check_value("ldoff_data", bus.mem_data_out, 32'hDEADBEEF);

        // Read+write together: store with read-before-write data
        mem_access("rw", 1'b1, 1'b1, 1'b1, 4'h4, 32'd1028, 32'h0BADF00D);
        check_value("rw_data", bus.mem_data_out, 32'hDEADBEEF);
        check_value("rw_rd", 32'(bus.mem_read_enable_out), 32'd1);
        mem_access("rwld", 1'b1, 1'b1, 1'b0, 4'h4, 32'd1028, 32'h0);
        check_value("rwld_data", bus.mem_data_out, 32'h0BADF00D);

        // Address wrap
        mem_access("wst", 1'b0, 1'b0, 1'b1, 4'h0, 32'(BASE_ADDR + 4 * MEM_DEPTH), 32'h12345678);
        mem_access("wld", 1'b1, 1'b1, 1'b0, 4'h9, 32'd1024, 32'h0);
        check_value("wrap_data", bus.mem_data_out, 32'h12345678);

        // Reset with a store pending does not commit it
        mem_access("pst", 1'b0, 1'b0, 1'b1, 4'h0, 32'd1036, 32'hAAAA5555);
        set_inputs(1'b1, 1'b0, 1'b1, 4'h1, 32'd1036, 32'h00000BAD);
        rst = 1'b0;
        tick();
        tick();
        check_value("rst2_ready", 32'(bus.ready), 32'd1);
        set_inputs(1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        rst = 1'b1;
        tick();
        mem_access("pld", 1'b1, 1'b1, 1'b0, 4'h1, 32'd1036, 32'h0);
        check_value("rst_nostore", bus.mem_data_out, 32'hAAAA5555);

        // Reset during BUSY aborts the store
        mem_access("pre", 1'b0, 1'b0, 1'b1, 4'h0, 32'd1032, 32'h11111111);
        set_inputs(1'b0, 1'b0, 1'b1, 4'h0, 32'd1032, 32'hCAFEF00D);
        tick();
        tick();
        check_value("mid_busy_ready", 32'(bus.ready), 32'd0);
        rst = 1'b0;
        set_inputs(1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
        #1;
        check_value("mid_rst_ready", 32'(bus.ready), 32'd1);
        tick();
        rst = 1'b1;
        #1;
        check_value("mid_idle_ready", 32'(bus.ready), 32'd1);
        check_value("mid_wb", 32'(bus.wb_enable_out), 32'd0);
        tick();
        check_value("mid_idle_ready2", 32'(bus.ready), 32'd1);
        mem_access("mld", 1'b1, 1'b1, 1'b0, 4'h6, 32'd1032, 32'h0);
        check_value("mid_old_data", bus.mem_data_out, 32'h11111111);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
